// File: rtl/ascensor_controlador_if.sv
// rtl/ascensor_controlador_if.sv - call buttons, floor feedback and command bundle for the elevator scheduler
interface ascensor_controlador_if;
  logic [3:0] b_piso;
  logic [3:0] ir_a_piso;
  logic [1:0] piso;
  logic       sube;
  logic       baja;
  logic       en;
  logic       puerta_abierta;
  logic       dir;
  logic [3:0] pendientes;
  logic       ocupado;

  modport master (
    output b_piso, ir_a_piso, piso,
    input  sube, baja, en, puerta_abierta, dir, pendientes, ocupado
  );

  modport slave (
    input  b_piso, ir_a_piso, piso,
    output sube, baja, en, puerta_abierta, dir, pendientes, ocupado
  );
endinterface

// File: rtl/ascensor_controlador.sv
// rtl/ascensor_controlador.sv - SCAN request scheduler for a 4-floor elevator
module ascensor_controlador #(
  parameter int T_VIAJE  = 50_000_000,
  parameter int T_PUERTA = 100_000_000,
  parameter int TW       = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  ascensor_controlador_if.slave bus
);

  typedef enum logic [1:0] {REPOSO, MOVIENDO, LLEGADA, PUERTA} estado_t;

  localparam logic [TW-1:0] CARGA_VIAJE  = TW'(T_VIAJE - 1);
  localparam logic [TW-1:0] CARGA_PUERTA = TW'(T_PUERTA - 1);

  estado_t       state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    pend, pend_n;
  logic          dir_r, dir_n;
  logic          arriba, abajo, pulsado;
  logic          sube_d, baja_d, puerta_d, ocupado_d;
  logic          sube_r, baja_r, puerta_r, ocupado_r;

  // Out-of-range slices (above floor 3, below floor 0) read as no request.
  always_comb begin
    arriba = 1'b0;
    abajo  = 1'b0;
    case (bus.piso)
      2'd0: begin arriba = |pend[3:1]; abajo = 1'b0;       end
      2'd1: begin arriba = |pend[3:2]; abajo = pend[0];    end
      2'd2: begin arriba = pend[3];    abajo = |pend[1:0]; end
      default: begin arriba = 1'b0;    abajo = |pend[2:0]; end
    endcase
  end

  assign pulsado = bus.b_piso[bus.piso] | bus.ir_a_piso[bus.piso];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REPOSO;
      timer     <= '0;
      pend      <= '0;
      dir_r     <= 1'b1;
      sube_r    <= 1'b0;
      baja_r    <= 1'b0;
      puerta_r  <= 1'b0;
      ocupado_r <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      pend      <= pend_n;
      dir_r     <= dir_n;
      sube_r    <= sube_d;
      baja_r    <= baja_d;
      puerta_r  <= puerta_d;
      ocupado_r <= ocupado_d;
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir_r;
    case (state)
      REPOSO: begin
        if (pend[bus.piso]) begin
          state_n = PUERTA;
        end else if (arriba && (dir_r || !abajo)) begin
          dir_n   = 1'b1;
          state_n = MOVIENDO;
        end else if (abajo) begin
          dir_n   = 1'b0;
          state_n = MOVIENDO;
        end
      end
      MOVIENDO: begin
        if (timer == '0) state_n = LLEGADA;
      end
      LLEGADA: begin
        if (pend[bus.piso]) begin
          state_n = PUERTA;
        end else if (dir_r ? arriba : abajo) begin
          state_n = MOVIENDO;
        end else if (dir_r ? abajo : arriba) begin
          dir_n   = ~dir_r;
          state_n = MOVIENDO;
        end else begin
          state_n = REPOSO;
        end
      end
      PUERTA: begin
        if (timer == '0 && !pulsado) state_n = REPOSO;
      end
      default: state_n = REPOSO;
    endcase

    // One shared counter: travel pacing in MOVIENDO, door interval in PUERTA.
    timer_n = timer;
    if (state_n == MOVIENDO && state != MOVIENDO) begin
      timer_n = CARGA_VIAJE;
    end else if (state_n == PUERTA && (state != PUERTA || pulsado)) begin
      timer_n = CARGA_PUERTA;
    end else if (timer != '0) begin
      timer_n = timer - TW'(1);
    end

    // The served floor is cleared on door entry and stays unlatched while the door is open.
    pend_n = pend | bus.b_piso | bus.ir_a_piso;
    if (state_n == PUERTA) pend_n[bus.piso] = 1'b0;
  end

  // Pulses are decided one cycle early so they land on the timer==0 cycle.
  always_comb begin
    sube_d    = (state == MOVIENDO) && (timer == TW'(1)) && dir_r  && (bus.piso != 2'd3);
    baja_d    = (state == MOVIENDO) && (timer == TW'(1)) && !dir_r && (bus.piso != 2'd0);
    puerta_d  = (state_n == PUERTA);
    ocupado_d = (state_n != REPOSO);
  end

  assign bus.sube           = sube_r;
  assign bus.baja           = baja_r;
  assign bus.en             = sube_r | baja_r;
  assign bus.puerta_abierta = puerta_r;
  assign bus.dir            = dir_r;
  assign bus.pendientes     = pend;
  assign bus.ocupado        = ocupado_r;

endmodule

// File: doc/ascensor_controlador.md
Name: ascensor_controlador

Overview:
- Request scheduler for the 4-floor elevator.
- Latches hall calls (b_piso) and cabin calls (ir_a_piso) into a pending-request register.
- Selects travel direction with a collective (SCAN) policy and paces travel with a per-floor timer.
- Drives the floor state machine through one-cycle sube/baja/en pulses, reads back the current floor on piso, and times the door-open interval at each served floor.

Parameters:
- T_VIAJE, 50_000_000, clock cycles spent travelling between adjacent floors (>=2).
- T_PUERTA, 100_000_000, clock cycles the door stays open at a served floor (>=1).
- TW, 27, width of the shared timer counter; must hold max(T_VIAJE, T_PUERTA).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- b_piso  in  4  hall-call buttons, bit i = floor i+1, level-sensitive.
- ir_a_piso  in  4  cabin buttons, bit i = floor i+1, level-sensitive.
- piso  in  2  current floor from the floor state machine (0..3).
- sube  out  1  one-cycle move-up command.
- baja  out  1  one-cycle move-down command.
- en  out  1  enable to the floor state machine, = sube | baja.
- puerta_abierta  out  1  door open.
- dir  out  1  current/last travel direction, 1 = up.
- pendientes  out  4  pending-request register, visible for display.
- ocupado  out  1  high whenever state != REPOSO.

Behaviour:
- Clock and reset: all state on posedge clk. rst high asynchronously forces:
  - state=REPOSO, pendientes=0, timer=0, dir=1.
  - sube=baja=en=0, puerta_abierta=0, ocupado=0.
  - Reset mid-travel or mid-door drops all requests; no pulse is emitted after rst.
- Request latch: every cycle, pendientes[i] <= pendientes[i] | b_piso[i] | ir_a_piso[i], except as below.
  - pendientes[piso] is cleared on the cycle the FSM enters PUERTA.
  - A press for floor piso while in PUERTA is not latched; it reloads the door timer (door held open).
  - Clear has priority over set only for that floor and only in PUERTA.
- Definitions: arriba = |pendientes[3:piso+1], abajo = |pendientes[piso-1:0]. A range out of bounds evaluates to 0.
- FSM, all outputs registered:
  - REPOSO:
    - If pendientes[piso]: go to PUERTA.
    - Else if arriba && (dir || !abajo): dir<=1, go to MOVIENDO.
    - Else if abajo: dir<=0, go to MOVIENDO.
    - Else stay.
  - MOVIENDO:
    - Entry loads timer=T_VIAJE-1; the timer decrements each cycle.
    - When timer==0: sube (dir=1) or baja (dir=0) is high for exactly that one cycle, en equal to it; go to LLEGADA.
  - LLEGADA: one cycle; piso now shows the new floor.
    - If pendientes[piso]: go to PUERTA.
    - Else if a request remains in dir: go to MOVIENDO.
    - Else if a request exists in the opposite direction: toggle dir, go to MOVIENDO.
    - Else go to REPOSO.
  - PUERTA:
    - Entry loads timer=T_PUERTA-1; puerta_abierta=1 for the whole state.
    - When timer==0 and no same-floor press: go to REPOSO.
- Latency and ordering:
  - Request at current floor in REPOSO: puerta_abierta high 2 cycles after the press is sampled (latch, then enter).
  - One floor of travel takes T_VIAJE cycles in MOVIENDO plus 1 cycle in LLEGADA.
- Safety:
  - sube never asserted when piso==3; baja never asserted when piso==0.
  - sube and baja are never high together.
  - puerta_abierta and en are never high together.
  - The scheduler never moves while puerta_abierta=1.
- Simultaneous requests above and below with dir=1 serve the upper floors first (direction retained).

Test Plan (T_VIAJE=4, T_PUERTA=3, piso from a behavioural floor model):
- Reset with piso=0, pulse b_piso=0100 for 1 cycle -> pendientes=0100; sube pulses exactly twice, 5 cycles apart; piso 0->2; puerta_abierta high 3 cycles; then pendientes=0000, REPOSO, ocupado=0.
- At piso=3 idle, ir_a_piso=0001 -> three baja pulses, dir=0, door opens at piso=0; sube never asserted.
- At piso=1 moving up toward 3, press b_piso=0001 -> floor 4 served first, then dir toggles and floor 1 is served; no door opens at floors 2 or 3.
- In PUERTA at piso=2, hold b_piso=0100 for 5 cycles -> door held; puerta_abierta stays high until 3 cycles after release; pendientes[2] stays 0.
- Assert rst during MOVIENDO with timer=1 -> no sube/baja pulse afterwards; all outputs 0 and dir=1 within the same cycle.
- Idle at piso=2, press ir_a_piso=0100 -> puerta_abierta high 2 cycles later; en stays 0 throughout.
